pipe_stage_regs: RTL and testbench

- Pipeline register bank (IF/DEC, DEC/EX, EX/MEM, MEM/WB) for the 5-stage RV32I core.
- Consumes the stall/flush outputs of the hazard unit and the EX-stage branch decision, then holds, advances or bubbles each stage.
- Emits the PC write enable.
- Keeps saturating stall/flush performance counters and a stall-watchdog error flag.

---
 rtl/core_pkg.sv | 30 +++
 rtl/pipe_stage_regs_pipe_reg.sv | 18 +
 rtl/pipe_stage_regs.sv | 92 +++++++++
 tb/tb_pipe_stage_regs.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared opcode/control-bundle types and bubble constants for the RV32I core
package core_pkg;
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;
  typedef struct packed {
    opcode_t     opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_used;
    logic        rs2_used;
    logic        reg_write;
    logic        mem_write;
    logic        mem_read2;
    logic [31:0] pc;
  } instr_t;
  localparam instr_t INSTR_BUBBLE = '{opcode: OP_IMM, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
    rs1_used: 1'b0, rs2_used: 1'b0, reg_write: 1'b0, mem_write: 1'b0, mem_read2: 1'b0, pc: 32'd0};
  localparam logic [31:0] NOP_IR = 32'h00000013;
endpackage

// File: rtl/pipe_stage_regs_pipe_reg.sv
// pipe_reg: stage register with hold enable and bubble-loading flush
module pipe_reg #(
  parameter int W = 1,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // reset and flush load the bubble; otherwise capture only when enabled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= BUBBLE;
    else if (flush) q <= BUBBLE;
    else if (en) q <= d;
endmodule

// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: IF/DEC, DEC/EX, EX/MEM, MEM/WB registers with hazard control and perf counters
module pipe_stage_regs
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNT_W = 16,
  parameter int MAX_STALL = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_ir,
  input  logic            if_valid,
  input  instr_t          dec_instr,
  input  logic [XLEN-1:0] dec_rs1_data,
  input  logic [XLEN-1:0] dec_rs2_data,
  input  logic [XLEN-1:0] dec_imm,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [XLEN-1:0] mem_dout,
  input  logic            lw_stall,
  input  logic            if_flush,
  input  logic            dec_flush,
  input  logic            ex_flush,
  input  logic            br_taken,
  output logic            pc_we,
  output logic [XLEN-1:0] dec_pc,
  output logic [31:0]     dec_ir,
  output logic            dec_valid,
  output instr_t          ex_instr,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic            ex_valid,
  output instr_t          mem_instr,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_store_data,
  output logic            mem_valid,
  output instr_t          wb_instr,
  output logic [XLEN-1:0] wb_alu_result,
  output logic [XLEN-1:0] wb_mem_dout,
  output logic            wb_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic            stall_err
);
  localparam int IW = $bits(instr_t);
  localparam int IF_W = XLEN + 33;
  localparam int DE_W = IW + 3 * XLEN + 1;
  localparam int EM_W = IW + 2 * XLEN + 1;
  localparam int RC_W = $clog2(MAX_STALL + 1);
  logic redir;
  logic [IF_W-1:0] if_q;
  logic [DE_W-1:0] de_q;
  logic [EM_W-1:0] em_q, mw_q;
  logic [RC_W-1:0] rc, rc_nxt;
  // a stalled branch has unresolved operands, so the stall masks any redirect
  assign redir = (br_taken | if_flush | dec_flush) & ~lw_stall;
  assign pc_we = rst_n & ~lw_stall;
  pipe_reg #(.W(IF_W), .BUBBLE({{XLEN{1'b0}}, NOP_IR, 1'b0})) u_if_dec (
    .clk(clk), .rst_n(rst_n), .en(~lw_stall), .flush(redir),
    .d({if_pc, if_ir, if_valid}), .q(if_q));
  pipe_reg #(.W(DE_W), .BUBBLE({INSTR_BUBBLE, {(3 * XLEN + 1){1'b0}}})) u_dec_ex (
    .clk(clk), .rst_n(rst_n), .en(~lw_stall), .flush(redir),
    .d({dec_instr, dec_rs1_data, dec_rs2_data, dec_imm, dec_valid}), .q(de_q));
  pipe_reg #(.W(EM_W), .BUBBLE({INSTR_BUBBLE, {(2 * XLEN + 1){1'b0}}})) u_ex_mem (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .flush(lw_stall | ex_flush),
    .d({ex_instr, ex_alu_result, ex_store_data, ex_valid}), .q(em_q));
  pipe_reg #(.W(EM_W), .BUBBLE({INSTR_BUBBLE, {(2 * XLEN + 1){1'b0}}})) u_mem_wb (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .flush(1'b0),
    .d({mem_instr, mem_alu_result, mem_dout, mem_valid}), .q(mw_q));
  assign {dec_pc, dec_ir, dec_valid} = if_q;
  assign {ex_instr, ex_rs1_data, ex_rs2_data, ex_imm, ex_valid} = de_q;
  assign {mem_instr, mem_alu_result, mem_store_data, mem_valid} = em_q;
  assign {wb_instr, wb_alu_result, wb_mem_dout, wb_valid} = mw_q;
  // consecutive-stall run length, saturating at the watchdog limit
  always_comb
    rc_nxt = !lw_stall ? '0 : (rc == RC_W'(MAX_STALL)) ? rc : rc + RC_W'(1);
  // saturating perf counters and sticky watchdog flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      rc <= '0;
      stall_err <= 1'b0;
    end else begin
      if (lw_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redir && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
      rc <= rc_nxt;
      if (lw_stall && rc_nxt == RC_W'(MAX_STALL)) stall_err <= 1'b1;
    end
endmodule

// File: tb/tb_pipe_stage_regs.sv
// tb_pipe_stage_regs: scoreboard bench for the pipeline register bank
module tb_pipe_stage_regs;
  import core_pkg::*;
  localparam int XLEN = 32;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [XLEN-1:0] if_pc, dec_rs1_data, dec_rs2_data, dec_imm, ex_alu_result, ex_store_data, mem_dout;
  logic [31:0] if_ir;
  logic if_valid, lw_stall, if_flush, dec_flush, ex_flush, br_taken;
  instr_t dec_instr, ex_instr, mem_instr, wb_instr;
  logic pc_we, dec_valid, ex_valid, mem_valid, wb_valid, stall_err;
  logic [XLEN-1:0] dec_pc, ex_rs1_data, ex_rs2_data, ex_imm, mem_alu_result, mem_store_data;
  logic [XLEN-1:0] wb_alu_result, wb_mem_dout;
  logic [31:0] dec_ir;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  int total = 0;
  int bad = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  pipe_stage_regs #(.XLEN(XLEN), .CNT_W(CNT_W), .MAX_STALL(2)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_ir(if_ir), .if_valid(if_valid),
    .dec_instr(dec_instr), .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
    .dec_imm(dec_imm), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .mem_dout(mem_dout), .lw_stall(lw_stall), .if_flush(if_flush), .dec_flush(dec_flush),
    .ex_flush(ex_flush), .br_taken(br_taken), .pc_we(pc_we), .dec_pc(dec_pc), .dec_ir(dec_ir),
    .dec_valid(dec_valid), .ex_instr(ex_instr), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_valid(ex_valid), .mem_instr(mem_instr),
    .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data), .mem_valid(mem_valid),
    .wb_instr(wb_instr), .wb_alu_result(wb_alu_result), .wb_mem_dout(wb_mem_dout),
    .wb_valid(wb_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .stall_err(stall_err));

  function automatic instr_t mk_instr(input logic [31:0] p);
    instr_t i;
    i = INSTR_BUBBLE;
    i.opcode = OP_REG;
    i.rd = p[6:2];
    i.rs1_used = 1'b1;
    i.reg_write = 1'b1;
    i.pc = p;
    return i;
  endfunction

  // stand-ins for decoder, regfile, ALU and data memory
  assign dec_instr = mk_instr(dec_pc);
  assign dec_rs1_data = dec_pc + 32'd100;
  assign dec_rs2_data = dec_pc + 32'd200;
  assign dec_imm = dec_pc + 32'd300;
  assign ex_alu_result = ex_rs1_data + ex_imm;
  assign ex_store_data = ex_rs2_data;
  assign mem_dout = mem_alu_result ^ 32'hA5A50000;

  // retire monitor: every valid WB entry must match the next expected pc and data
  always @(negedge clk)
    if (rst_n && wb_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected got pc=%h want none", wb_instr.pc);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (wb_instr.pc !== e || wb_instr.reg_write !== 1'b1 || wb_alu_result !== 2 * e + 32'd400 ||
            wb_mem_dout !== ((2 * e + 32'd400) ^ 32'hA5A50000)) begin
          bad++;
          $display("FAIL wb_retire got pc=%h alu=%h dout=%h want pc=%h alu=%h dout=%h", wb_instr.pc,
                   wb_alu_result, wb_mem_dout, e, 2 * e + 32'd400, (2 * e + 32'd400) ^ 32'hA5A50000);
        end
      end
    end

  task automatic drive(input logic [31:0] p, input logic v, input logic lw, input logic br, input logic exf);
    if_pc = p;
    if_ir = {p[19:0], 12'h033};
    if_valid = v;
    lw_stall = lw;
    br_taken = br;
    ex_flush = exf;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] p, input logic push);
    drive(p, 1'b1, 1'b0, 1'b0, 1'b0);
    if (push) sb.push_back(p);
    step();
  endtask

  task automatic drain();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10 && sb.size() != 0; k++) step();
    step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_flow();
    feed(32'h0, 1'b1);
    total++;
    if (dec_pc !== 32'h0 || dec_valid !== 1'b1 || dec_ir !== 32'h00000033) begin
      bad++;
      $display("FAIL flow_ifdec got pc=%h v=%b ir=%h want 0 1 00000033", dec_pc, dec_valid, dec_ir);
    end
    feed(32'h4, 1'b1);
    feed(32'h8, 1'b1);
    drive(32'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    total++;
    if (wb_valid !== 1'b1 || wb_instr.pc !== 32'h0) begin
      bad++;
      $display("FAIL flow_latency got wb_v=%b pc=%h want 1 0", wb_valid, wb_instr.pc);
    end
    total++;
    if (dec_pc !== 32'hC || dec_valid !== 1'b0) begin
      bad++;
      $display("FAIL flow_invalid_reg got pc=%h v=%b want c 0", dec_pc, dec_valid);
    end
    drain();
    total++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || pc_we !== 1'b1) begin
      bad++;
      $display("FAIL flow_counters got s=%0d f=%0d we=%b want 0 0 1", stall_cnt, flush_cnt, pc_we);
    end
  endtask

  task automatic test_load_use();
    feed(32'h10, 1'b1);
    feed(32'h14, 1'b1);
    total++;
    if (ex_instr.pc !== 32'h10 || ex_valid !== 1'b1) begin
      bad++;
      $display("FAIL lu_pre got ex_pc=%h v=%b want 10 1", ex_instr.pc, ex_valid);
    end
    drive(32'h18, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    total++;
    if (pc_we !== 1'b0) begin
      bad++;
      $display("FAIL lu_pc_we got %b want 0", pc_we);
    end
    step();
    total++;
    if (ex_instr.pc !== 32'h10 || dec_pc !== 32'h14 || dec_valid !== 1'b1 || mem_valid !== 1'b0 || stall_cnt !== 4'd1) begin
      bad++;
      $display("FAIL lu_hold got ex=%h dec=%h dv=%b mv=%b s=%0d want 10 14 1 0 1",
               ex_instr.pc, dec_pc, dec_valid, mem_valid, stall_cnt);
    end
    drive(32'h18, 1'b1, 1'b0, 1'b0, 1'b0);
    sb.push_back(32'h18);
    step();
    total++;
    if (ex_instr.pc !== 32'h14 || mem_instr.pc !== 32'h10 || mem_valid !== 1'b1 || dec_pc !== 32'h18) begin
      bad++;
      $display("FAIL lu_resume got ex=%h mem=%h mv=%b dec=%h want 14 10 1 18",
               ex_instr.pc, mem_instr.pc, mem_valid, dec_pc);
    end
    feed(32'h1C, 1'b1);
    drain();
    total++;
    if (stall_err !== 1'b0) begin
      bad++;
      $display("FAIL lu_no_err got %b want 0", stall_err);
    end
  endtask

  task automatic test_branch();
    feed(32'h20, 1'b1);
    feed(32'h24, 1'b0);
    drive(32'h28, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    total++;
    if (dec_valid !== 1'b0 || ex_valid !== 1'b0 || ex_instr.reg_write !== 1'b0 || dec_ir !== NOP_IR) begin
      bad++;
      $display("FAIL br_bubble got dv=%b ev=%b rw=%b ir=%h want 0 0 0 00000013",
               dec_valid, ex_valid, ex_instr.reg_write, dec_ir);
    end
    total++;
    if (mem_instr.pc !== 32'h20 || mem_valid !== 1'b1 || flush_cnt !== 4'd1) begin
      bad++;
      $display("FAIL br_mem got pc=%h v=%b f=%0d want 20 1 1", mem_instr.pc, mem_valid, flush_cnt);
    end
    feed(32'h40, 1'b1);
    drain();
  endtask

  task automatic test_conflict();
    feed(32'h50, 1'b1);
    feed(32'h54, 1'b0);
    drive(32'h58, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    total++;
    if (ex_instr.pc !== 32'h50 || ex_valid !== 1'b1 || dec_pc !== 32'h54 || dec_valid !== 1'b1 ||
        mem_valid !== 1'b0 || flush_cnt !== 4'd1 || stall_cnt !== 4'd2) begin
      bad++;
      $display("FAIL conf_stall got ex=%h ev=%b dec=%h dv=%b mv=%b f=%0d s=%0d want 50 1 54 1 0 1 2",
               ex_instr.pc, ex_valid, dec_pc, dec_valid, mem_valid, flush_cnt, stall_cnt);
    end
    drive(32'h58, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    total++;
    if (dec_valid !== 1'b0 || ex_valid !== 1'b0 || mem_instr.pc !== 32'h50 || mem_valid !== 1'b1 || flush_cnt !== 4'd2) begin
      bad++;
      $display("FAIL conf_flush got dv=%b ev=%b mem=%h mv=%b f=%0d want 0 0 50 1 2",
               dec_valid, ex_valid, mem_instr.pc, mem_valid, flush_cnt);
    end
    feed(32'h80, 1'b1);
    drain();
  endtask

  task automatic test_flush_sources();
    feed(32'h60, 1'b0);
    drive(32'h64, 1'b1, 1'b0, 1'b0, 1'b0);
    if_flush = 1'b1;
    step();
    if_flush = 1'b0;
    total++;
    if (dec_valid !== 1'b0 || ex_valid !== 1'b0 || flush_cnt !== 4'd3) begin
      bad++;
      $display("FAIL if_flush got dv=%b ev=%b f=%0d want 0 0 3", dec_valid, ex_valid, flush_cnt);
    end
    drive(32'h68, 1'b1, 1'b0, 1'b0, 1'b0);
    dec_flush = 1'b1;
    step();
    dec_flush = 1'b0;
    total++;
    if (dec_valid !== 1'b0 || flush_cnt !== 4'd4) begin
      bad++;
      $display("FAIL dec_flush got dv=%b f=%0d want 0 4", dec_valid, flush_cnt);
    end
    feed(32'h70, 1'b0);
    feed(32'h74, 1'b1);
    drive(32'h78, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    total++;
    if (mem_valid !== 1'b0 || ex_instr.pc !== 32'h74 || ex_valid !== 1'b1 || flush_cnt !== 4'd4) begin
      bad++;
      $display("FAIL ex_flush got mv=%b ex=%h ev=%b f=%0d want 0 74 1 4", mem_valid, ex_instr.pc, ex_valid, flush_cnt);
    end
    drain();
  endtask

  task automatic test_watchdog();
    drive(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    total++;
    if (stall_err !== 1'b0) begin
      bad++;
      $display("FAIL wd_first got %b want 0", stall_err);
    end
    step();
    total++;
    if (stall_err !== 1'b1) begin
      bad++;
      $display("FAIL wd_second got %b want 1", stall_err);
    end
    step();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    total++;
    if (stall_err !== 1'b1 || stall_cnt !== 4'd5) begin
      bad++;
      $display("FAIL wd_sticky got err=%b s=%0d want 1 5", stall_err, stall_cnt);
    end
    drive(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) step();
    total++;
    if (stall_cnt !== 4'd15) begin
      bad++;
      $display("FAIL stall_cnt_reach got %0d want 15", stall_cnt);
    end
    repeat (10) step();
    total++;
    if (stall_cnt !== 4'd15) begin
      bad++;
      $display("FAIL stall_cnt_sat got %0d want 15", stall_cnt);
    end
    drive(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (11) step();
    total++;
    if (flush_cnt !== 4'd15) begin
      bad++;
      $display("FAIL flush_cnt_reach got %0d want 15", flush_cnt);
    end
    repeat (3) step();
    total++;
    if (flush_cnt !== 4'd15 || stall_err !== 1'b1) begin
      bad++;
      $display("FAIL flush_cnt_sat got f=%0d err=%b want 15 1", flush_cnt, stall_err);
    end
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_reset();
    feed(32'h90, 1'b0);
    drive(32'h90, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (dec_valid !== 1'b0 || ex_valid !== 1'b0 || mem_valid !== 1'b0 || wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid got %b%b%b%b want 0000", dec_valid, ex_valid, mem_valid, wb_valid);
    end
    total++;
    if (ex_instr !== INSTR_BUBBLE || ex_instr.reg_write !== 1'b0 || dec_ir !== NOP_IR || dec_pc !== 32'h0) begin
      bad++;
      $display("FAIL rst_bubble got ex=%h ir=%h pc=%h want %h 00000013 0", ex_instr, dec_ir, dec_pc, INSTR_BUBBLE);
    end
    total++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || stall_err !== 1'b0 || pc_we !== 1'b0 || wb_alu_result !== 32'h0) begin
      bad++;
      $display("FAIL rst_state got s=%0d f=%0d err=%b we=%b alu=%h want 0 0 0 0 0",
               stall_cnt, flush_cnt, stall_err, pc_we, wb_alu_result);
    end
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1);
  end

  initial begin
    if_flush = 1'b0;
    dec_flush = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    test_flow();
    test_load_use();
    test_branch();
    test_conflict();
    test_flush_sources();
    test_watchdog();
    test_reset();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_empty got %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
